// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request/response handshake bundle for the ALU issue controller
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one ALU op at a time, captures result and NZCV status
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [2:0]        alu_control,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [31:0]       alu_bus_in,
    input  logic              alu_c_in,
    input  logic              alu_v_in,
    output logic [3:0]        flags_nzcv,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Counter preload: the capture happens on the edge where the count is zero.
    localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        capture;
    logic        handshake;
    logic [31:0] result_q;

    assign bus.rsp_result = result_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        handshake     = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = ~rst;
                if (bus.req_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: preloaded on accept, counts down while waiting on the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= LAT_M1;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // ALU drive registers, result capture and NZCV status (nop leaves flags alone)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control <= 3'b000;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            result_q    <= 32'd0;
            flags_nzcv  <= 4'b0000;
        end else if (accept) begin
            alu_control <= bus.req_op;
            alu_a       <= bus.req_a;
            alu_b       <= bus.req_b;
        end else if (capture) begin
            result_q    <= alu_bus_in;
            if (alu_control != 3'b000) begin
                flags_nzcv <= {alu_bus_in[31], (alu_bus_in == 32'd0), alu_c_in, alu_v_in};
            end
            alu_control <= 3'b000;
        end
    end

    // Completed-operation counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done <= '0;
        end else if (handshake) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule
